// File: rtl/reorder_buffer_if.sv
// FU class encoding shared with decode, plus the ROB's dispatch/writeback/operand/commit bundle.
// The slave modport is the ROB's view of the bus; the master modport is the pipeline's view.
package decode_pkg;
  typedef enum logic [2:0] {FU_ALU, FU_MUL, FU_DIV, FU_LSU, FU_BRU, FU_CSR} fu_e;
endpackage

interface reorder_buffer_if #(
  parameter int ROB_DEPTH     = 64,
  parameter int ROB_IDX_WIDTH = $clog2(ROB_DEPTH),
  parameter int PLEN          = 32,
  parameter int XLEN          = 32,
  parameter int NUM_WB        = 4,
  parameter int NUM_RD        = 8
);
  logic [3:0]                               dispatch_valid_i;
  logic [3:0][PLEN-1:0]                     dispatch_pc_i;
  decode_pkg::fu_e [3:0]                    dispatch_fu_type_i;
  logic [3:0][4:0]                          dispatch_areg_i;
  logic [3:0]                               dispatch_has_rd_i;
  logic                                     rob_ready_o;
  logic [ROB_IDX_WIDTH-1:0]                 rob_tail_ptr_o;
  logic [NUM_WB-1:0]                        wb_valid_i;
  logic [NUM_WB-1:0][ROB_IDX_WIDTH-1:0]     wb_rob_idx_i;
  logic [NUM_WB-1:0][XLEN-1:0]              wb_data_i;
  logic [NUM_WB-1:0]                        wb_exception_i;
  logic [NUM_RD-1:0][ROB_IDX_WIDTH-1:0]     opnd_rob_idx_i;
  logic [NUM_RD-1:0]                        opnd_ready_o;
  logic [NUM_RD-1:0][XLEN-1:0]              opnd_data_o;
  logic [3:0]                               commit_valid_o;
  logic [3:0]                               commit_we_o;
  logic [3:0][4:0]                          commit_areg_o;
  logic [3:0][ROB_IDX_WIDTH-1:0]            commit_rob_idx_o;
  logic [3:0][XLEN-1:0]                     commit_data_o;
  logic [3:0][PLEN-1:0]                     commit_pc_o;
  logic                                     flush_o;
  logic [PLEN-1:0]                          flush_pc_o;
  logic                                     flush_i;

  modport slave (
    input  dispatch_valid_i, dispatch_pc_i, dispatch_fu_type_i, dispatch_areg_i, dispatch_has_rd_i,
    input  wb_valid_i, wb_rob_idx_i, wb_data_i, wb_exception_i, opnd_rob_idx_i, flush_i,
    output rob_ready_o, rob_tail_ptr_o, opnd_ready_o, opnd_data_o,
    output commit_valid_o, commit_we_o, commit_areg_o, commit_rob_idx_o, commit_data_o, commit_pc_o,
    output flush_o, flush_pc_o
  );

  modport master (
    output dispatch_valid_i, dispatch_pc_i, dispatch_fu_type_i, dispatch_areg_i, dispatch_has_rd_i,
    output wb_valid_i, wb_rob_idx_i, wb_data_i, wb_exception_i, opnd_rob_idx_i, flush_i,
    input  rob_ready_o, rob_tail_ptr_o, opnd_ready_o, opnd_data_o,
    input  commit_valid_o, commit_we_o, commit_areg_o, commit_rob_idx_o, commit_data_o, commit_pc_o,
    input  flush_o, flush_pc_o
  );
endinterface

// File: rtl/reorder_buffer.sv
// 4-wide in-order-retire ROB: dispatch/writeback land at the edge, operand reads and commit are combinational.
// Backpressure: rob_ready_o drops below 4 free entries; a flush blocks dispatch and commit for its cycle.
module reorder_buffer #(
  parameter int ROB_DEPTH     = 64,
  parameter int ROB_IDX_WIDTH = $clog2(ROB_DEPTH),
  parameter int PLEN          = 32,
  parameter int XLEN          = 32,
  parameter int NUM_WB        = 4,
  parameter int NUM_RD        = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  reorder_buffer_if.slave bus
);
  localparam int          IW      = ROB_IDX_WIDTH;
  localparam logic [IW:0] DEPTH_C = (IW+1)'(ROB_DEPTH);

  typedef struct packed {
    logic            valid;
    logic            done;
    logic            exc;
    logic            bubble;
    logic [PLEN-1:0] pc;
    decode_pkg::fu_e fu;
    logic [4:0]      areg;
    logic            has_rd;
    logic [XLEN-1:0] data;
  } rob_entry_t;

  rob_entry_t      r_rob [ROB_DEPTH];
  logic [IW-1:0]   r_head;
  logic [IW-1:0]   r_tail;
  logic [IW:0]     r_count;
  logic            r_flush;
  logic [PLEN-1:0] r_flush_pc;

  logic            w_flushing;
  logic            w_ready;
  logic            w_disp_acc;
  logic [2:0]      w_n_disp;
  logic [2:0]      w_n_acc;
  logic [2:0]      w_n_commit;
  logic [3:0]      w_commit;
  logic            w_exc_head;
  logic [IW-1:0]   w_slot_idx [4];

  assign w_flushing          = bus.flush_i || r_flush;
  assign w_ready             = (DEPTH_C - r_count) >= (IW+1)'(4);
  assign bus.rob_ready_o     = w_ready;
  assign bus.rob_tail_ptr_o  = r_tail;
  assign bus.flush_o         = r_flush;
  assign bus.flush_pc_o      = r_flush_pc;

  // Lanes up to the highest valid one are allocated so tag = tail + lane holds for rename.
  always_comb begin
    w_n_disp = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.dispatch_valid_i[i]) w_n_disp = 3'(i + 1);
    end
    w_disp_acc = w_ready && !w_flushing && (|bus.dispatch_valid_i);
    w_n_acc    = w_disp_acc ? w_n_disp : 3'd0;
  end

  always_comb begin
    logic stop;
    stop       = 1'b0;
    w_commit   = '0;
    w_n_commit = 3'd0;
    for (int k = 0; k < 4; k++) begin
      w_slot_idx[k] = r_head + IW'(k);
      if (!stop && !w_flushing && r_rob[w_slot_idx[k]].valid && r_rob[w_slot_idx[k]].done &&
          !r_rob[w_slot_idx[k]].exc && (r_count > (IW+1)'(k))) begin
        w_commit[k] = 1'b1;
        w_n_commit  = w_n_commit + 3'd1;
      end else begin
        stop = 1'b1;
      end
    end
    w_exc_head = !w_flushing && (r_count != '0) && r_rob[r_head].valid &&
                 r_rob[r_head].done && r_rob[r_head].exc;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bus.commit_valid_o[k]   = w_commit[k] && !r_rob[w_slot_idx[k]].bubble;
      bus.commit_we_o[k]      = bus.commit_valid_o[k] && r_rob[w_slot_idx[k]].has_rd &&
                                (r_rob[w_slot_idx[k]].areg != 5'd0);
      bus.commit_areg_o[k]    = r_rob[w_slot_idx[k]].areg;
      bus.commit_rob_idx_o[k] = w_slot_idx[k];
      bus.commit_data_o[k]    = r_rob[w_slot_idx[k]].data;
      bus.commit_pc_o[k]      = r_rob[w_slot_idx[k]].pc;
    end
  end

  // Same-cycle writeback forwards to issue; the highest-numbered matching port wins.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      bus.opnd_ready_o[r] = r_rob[bus.opnd_rob_idx_i[r]].done;
      bus.opnd_data_o[r]  = r_rob[bus.opnd_rob_idx_i[r]].data;
      for (int p = 0; p < NUM_WB; p++) begin
        if (bus.wb_valid_i[p] && (bus.wb_rob_idx_i[p] == bus.opnd_rob_idx_i[r])) begin
          bus.opnd_ready_o[r] = 1'b1;
          bus.opnd_data_o[r]  = bus.wb_data_i[p];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || w_flushing) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rob[i].valid <= 1'b0;
        r_rob[i].done  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < w_n_acc) begin
          r_rob[r_tail + IW'(i)].valid  <= 1'b1;
          r_rob[r_tail + IW'(i)].done   <= !bus.dispatch_valid_i[i];
          r_rob[r_tail + IW'(i)].exc    <= 1'b0;
          r_rob[r_tail + IW'(i)].bubble <= !bus.dispatch_valid_i[i];
          r_rob[r_tail + IW'(i)].pc     <= bus.dispatch_pc_i[i];
          r_rob[r_tail + IW'(i)].fu     <= bus.dispatch_fu_type_i[i];
          r_rob[r_tail + IW'(i)].areg   <= bus.dispatch_areg_i[i];
          r_rob[r_tail + IW'(i)].has_rd <= bus.dispatch_valid_i[i] && bus.dispatch_has_rd_i[i];
        end
      end
      for (int p = 0; p < NUM_WB; p++) begin
        if (bus.wb_valid_i[p] && r_rob[bus.wb_rob_idx_i[p]].valid) begin
          r_rob[bus.wb_rob_idx_i[p]].done <= 1'b1;
          r_rob[bus.wb_rob_idx_i[p]].data <= bus.wb_data_i[p];
          r_rob[bus.wb_rob_idx_i[p]].exc  <= bus.wb_exception_i[p];
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (w_commit[k]) r_rob[w_slot_idx[k]].valid <= 1'b0;
      end
      r_head  <= r_head + IW'(w_n_commit);
      r_tail  <= r_tail + IW'(w_n_acc);
      r_count <= r_count + (IW+1)'(w_n_acc) - (IW+1)'(w_n_commit);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_flush    <= 1'b0;
      r_flush_pc <= '0;
    end else begin
      r_flush <= w_exc_head;
      if (w_exc_head) r_flush_pc <= r_rob[r_head].pc;
    end
  end
endmodule
